// File: rtl/display_spi_scheduler.sv
// display_spi_scheduler
// Arbitrating SPI write master for the display SPI slave.
// - reg0 is the enable register and reg1..reg8 are the digits.
// - Two requesters post {address, value} with a req/ack handshake.
// - Grants are round-robin. Each accepted write with a valid address is
//   sent as one 16-bit frame {CMD_WRITE, addr, value}, MSB first.
// - SPI mode 3: sclk idles high, the slave samples on the sclk rising edge,
//   and ss and mosi idle high.
//
// Ports:
//   clock_5meg_i          system clock; all logic runs on its rising edge
//   rst_low_i             synchronous reset, active low
//   reqN_i/addrN_i/dataN_i  requester N write request, address and value
//   ackN_o                one-cycle accept pulse to requester N
//   err_o                 pulses with ack when the accepted address is out of range
//   busy_o                high from the accept cycle through the end of the gap
//   frame_done_o          one-cycle pulse when ss returns high after a full frame
//   spi_sclk_o/spi_ss_o/spi_mosi_o  SPI bus; all registered
module display_spi_scheduler #(
  parameter int         HALF_PERIOD   = 2,
  parameter int         GAP_CYCLES    = 4,
  parameter int         NUM_REGISTERS = 9,
  parameter logic [3:0] CMD_WRITE     = 4'b0001
) (
  input  logic       clock_5meg_i,
  input  logic       rst_low_i,
  input  logic       req0_i,
  input  logic [3:0] addr0_i,
  input  logic [7:0] data0_i,
  output logic       ack0_o,
  input  logic       req1_i,
  input  logic [3:0] addr1_i,
  input  logic [7:0] data1_i,
  output logic       ack1_o,
  output logic       err_o,
  output logic       busy_o,
  output logic       frame_done_o,
  output logic       spi_sclk_o,
  output logic       spi_ss_o,
  output logic       spi_mosi_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SCK_LO = 3'd2,
    SCK_HI = 3'd3,
    HOLD   = 3'd4,
    GAP    = 3'd5
  } state_t;

  localparam logic [7:0] HALF_LAST = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [3:0] LAST_BIT  = 4'd15;

  // True when the address has no matching slave register.
  function automatic logic addr_is_bad(input logic [3:0] addr);
    return ({28'd0, addr} >= 32'(NUM_REGISTERS));
  endfunction

  // Builds the write frame as it appears on the wire, MSB first.
  function automatic logic [15:0] build_frame(input logic [3:0] addr, input logic [7:0] value);
    return {CMD_WRITE, addr, value};
  endfunction

  state_t      state_r, state_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [3:0]  bit_r, bit_s;
  // The MSB of the shift register drives mosi directly. The register is
  // filled with ones while idle, so mosi idles high.
  logic [15:0] shift_r, shift_s;
  logic        prefer_r, prefer_s;
  logic        sclk_r, sclk_s;
  logic        ss_r, ss_s;
  logic        ack0_r, ack0_s;
  logic        ack1_r, ack1_s;
  logic        err_r, err_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;

  logic        want0_s, want1_s, pick1_s;
  logic [3:0]  sel_addr_s;
  logic [7:0]  sel_data_s;
  logic [15:0] frame_s;

  // A request is masked while its own ack is pulsing.
  // This stops it from being granted a second time before the requester drops req.
  assign want0_s    = req0_i & ~ack0_r;
  assign want1_s    = req1_i & ~ack1_r;
  // prefer_r = 1 means requester 1 wins a tie.
  assign pick1_s    = want1_s & (~want0_s | prefer_r);
  assign sel_addr_s = pick1_s ? addr1_i : addr0_i;
  assign sel_data_s = pick1_s ? data1_i : data0_i;
  assign frame_s    = build_frame(sel_addr_s, sel_data_s);

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    bit_s    = bit_r;
    shift_s  = shift_r;
    prefer_s = prefer_r;
    sclk_s   = sclk_r;
    ss_s     = ss_r;
    ack0_s   = 1'b0;
    ack1_s   = 1'b0;
    err_s    = 1'b0;
    busy_s   = busy_r;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (want0_s || want1_s) begin
          ack0_s   = ~pick1_s;
          ack1_s   = pick1_s;
          prefer_s = ~pick1_s;
          if (addr_is_bad(sel_addr_s)) begin
            // Accept and flag the write, but send nothing.
            err_s   = 1'b1;
            state_s = IDLE;
          end else begin
            shift_s = frame_s;
            ss_s    = 1'b0;
            busy_s  = 1'b1;
            cnt_s   = 8'd0;
            bit_s   = 4'd0;
            state_s = SETUP;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (cnt_r == HALF_LAST) begin
          cnt_s   = 8'd0;
          sclk_s  = 1'b0;
          state_s = SCK_LO;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      SCK_LO: begin
        if (cnt_r == HALF_LAST) begin
          cnt_s   = 8'd0;
          sclk_s  = 1'b1;
          state_s = SCK_HI;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      SCK_HI: begin
        if (cnt_r == HALF_LAST) begin
          cnt_s = 8'd0;
          if (bit_r == LAST_BIT) begin
            state_s = HOLD;
          end else begin
            // Present the next bit on the falling edge.
            sclk_s  = 1'b0;
            bit_s   = bit_r + 4'd1;
            shift_s = {shift_r[14:0], 1'b1};
            state_s = SCK_LO;
          end
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      HOLD: begin
        if (cnt_r == HALF_LAST) begin
          cnt_s   = 8'd0;
          ss_s    = 1'b1;
          shift_s = 16'hFFFF;
          done_s  = 1'b1;
          state_s = GAP;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      GAP: begin
        if (cnt_r == GAP_LAST) begin
          cnt_s   = 8'd0;
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 8'd0;
        sclk_s  = 1'b1;
        ss_s    = 1'b1;
        shift_s = 16'hFFFF;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  // Reset truncates any frame in progress and returns the bus to idle levels.
  always_ff @(posedge clock_5meg_i) begin
    if (!rst_low_i) begin
      state_r  <= IDLE;
      cnt_r    <= 8'd0;
      bit_r    <= 4'd0;
      shift_r  <= 16'hFFFF;
      prefer_r <= 1'b0;
      sclk_r   <= 1'b1;
      ss_r     <= 1'b1;
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      err_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      bit_r    <= bit_s;
      shift_r  <= shift_s;
      prefer_r <= prefer_s;
      sclk_r   <= sclk_s;
      ss_r     <= ss_s;
      ack0_r   <= ack0_s;
      ack1_r   <= ack1_s;
      err_r    <= err_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign ack0_o       = ack0_r;
  assign ack1_o       = ack1_r;
  assign err_o        = err_r;
  assign busy_o       = busy_r;
  assign frame_done_o = done_r;
  assign spi_sclk_o   = sclk_r;
  assign spi_ss_o     = ss_r;
  assign spi_mosi_o   = shift_r[15];

endmodule
